// File: rtl/sar_logic_param.sv
// N-bit charge-redistribution SAR sequencer: sample window, MSB-first binary search, held result.
// Define SAR_AVG_EN to average 2**AVG_LOG2 back-to-back conversions per request.
module sar_logic_param #(
   parameter int unsigned N             = 10,
   parameter int unsigned SAMPLE_CYCLES = 2,
   parameter int unsigned AVG_LOG2      = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         cont_mode,
   input  logic         comparator_out,
   output logic [N-1:0] D,
   output logic         sample_clk,
   output logic         reg_clk,
   output logic         busy,
   output logic [N-1:0] dout,
   output logic         EOC
);

   localparam int unsigned KW = $clog2(N);
   localparam int unsigned SW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
   localparam bit ParamsOk = (N >= 2) && (N <= 16) && (SAMPLE_CYCLES >= 1) && (AVG_LOG2 <= 4);

   if (!ParamsOk) begin : gen_param_check
      $error("sar_logic_param: parameter out of range");
   end

   typedef enum logic [1:0] {StIdle, StSample, StConvert, StDone} state_e;

   state_e        state_q, state_d;
   logic [SW-1:0] cnt_q, cnt_d;
   logic [KW-1:0] k_q, k_d;
   logic [N-1:0]  dac_q, dac_d;
   logic [N-1:0]  dout_q, dout_d;
   logic          sample_q, sample_d;
   logic          busy_q, busy_d;
   logic          eoc_q, eoc_d;
   logic [N-1:0]  code;
   logic          more;

`ifdef SAR_AVG_EN
   localparam int unsigned AW = N + AVG_LOG2;
   localparam int unsigned CW = AVG_LOG2 + 1;

   logic [AW-1:0] acc_q, acc_d, sum;
   logic [CW-1:0] conv_q, conv_d;

   // Counter wraps to zero on the last conversion of a group.
   assign more = (conv_q != '0);
`else
   assign more = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      k_d      = k_q;
      dac_d    = dac_q;
      dout_d   = dout_q;
      sample_d = 1'b0;
      busy_d   = 1'b1;
      eoc_d    = 1'b0;
      code     = dac_q;
`ifdef SAR_AVG_EN
      acc_d    = acc_q;
      conv_d   = conv_q;
      sum      = '0;
`endif
      unique case (state_q)
         StIdle: begin
            busy_d = 1'b0;
            dac_d  = '0;
            if (start || cont_mode) begin
               state_d  = StSample;
               cnt_d    = '0;
               sample_d = 1'b1;
               busy_d   = 1'b1;
`ifdef SAR_AVG_EN
               acc_d    = '0;
               conv_d   = '0;
`endif
            end
         end
         StSample: begin
            if (cnt_q == SW'(SAMPLE_CYCLES - 1)) begin
               state_d = StConvert;
               dac_d   = {1'b1, {(N-1){1'b0}}};
               k_d     = KW'(N - 1);
            end else begin
               cnt_d    = cnt_q + 1'b1;
               sample_d = 1'b1;
            end
         end
         StConvert: begin
            // Trial bit is 1, so the comparator value is exactly the decision.
            code[k_q] = comparator_out;
            if (k_q != '0) begin
               code[KW'(k_q - 1'b1)] = 1'b1;
               k_d = KW'(k_q - 1'b1);
            end else begin
               state_d = StDone;
`ifdef SAR_AVG_EN
               sum   = acc_q + AW'(code);
               acc_d = sum;
               if (conv_q == CW'((1 << AVG_LOG2) - 1)) begin
                  dout_d = sum[AVG_LOG2 +: N];
                  eoc_d  = 1'b1;
                  conv_d = '0;
               end else begin
                  conv_d = conv_q + 1'b1;
               end
`else
               dout_d = code;
               eoc_d  = 1'b1;
`endif
            end
            dac_d = code;
         end
         StDone: begin
            dac_d = '0;
            if (more || start || cont_mode) begin
               state_d  = StSample;
               cnt_d    = '0;
               sample_d = 1'b1;
`ifdef SAR_AVG_EN
               if (!more) acc_d = '0;
`endif
            end else begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         k_q      <= '0;
         dac_q    <= '0;
         dout_q   <= '0;
         sample_q <= 1'b0;
         busy_q   <= 1'b0;
         eoc_q    <= 1'b0;
`ifdef SAR_AVG_EN
         acc_q    <= '0;
         conv_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         k_q      <= k_d;
         dac_q    <= dac_d;
         dout_q   <= dout_d;
         sample_q <= sample_d;
         busy_q   <= busy_d;
         eoc_q    <= eoc_d;
`ifdef SAR_AVG_EN
         acc_q    <= acc_d;
         conv_q   <= conv_d;
`endif
      end
   end

   assign D          = dac_q;
   assign sample_clk = sample_q;
   assign reg_clk    = (state_q == StConvert);
   assign busy       = busy_q;
   assign dout       = dout_q;
   assign EOC        = eoc_q;

endmodule

// File: tb/tb_sar_logic_param.sv
// Randomised bench for sar_logic_param: ideal comparator on a bench Vin, results vs search rules.
// Covers both the default build and SAR_AVG_EN.
module tb_sar_logic_param;

`ifdef SAR_AVG_EN
   localparam int A = 2;
`else
   localparam int A = 0;
`endif
   localparam int N10 = 10;
   localparam int S10 = 2;
   localparam int N12 = 12;
   localparam int S12 = 1;
   localparam int L10 = (S10 + N10 + 1) << A;
   localparam int L12 = (S12 + N12 + 1) << A;

   logic clk = 1'b0;
   logic rst_n;
   logic start10, start12, cont10, cont12;
   logic force_en, force_val;
   int   vin10, vin12;
   logic [9:0]  d10, dout10;
   logic [11:0] d12, dout12;
   logic samp10, regclk10, busy10, eoc10;
   logic samp12, regclk12, busy12, eoc12;
   logic cmp10, cmp12;
   int   cyc = 0;

   int n_checks = 0;
   int n_fail   = 0;
   int trace[16];
   int vin_seq[$];

   assign cmp10 = force_en ? force_val : (vin10 >= int'(d10));
   assign cmp12 = (vin12 >= int'(d12));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sar_logic_param #(.N(N10), .SAMPLE_CYCLES(S10), .AVG_LOG2(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start10), .cont_mode(cont10), .comparator_out(cmp10),
      .D(d10), .sample_clk(samp10), .reg_clk(regclk10), .busy(busy10), .dout(dout10), .EOC(eoc10)
   );

   sar_logic_param #(.N(N12), .SAMPLE_CYCLES(S12), .AVG_LOG2(2)) dut12 (
      .clk(clk), .rst_n(rst_n), .start(start12), .cont_mode(cont12), .comparator_out(cmp12),
      .D(d12), .sample_clk(samp12), .reg_clk(regclk12), .busy(busy12), .dout(dout12), .EOC(eoc12)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One start pulse, then watch for a bounded window; optionally re-pulse start mid-CONVERT.
   task automatic do_conv(input bit sel, input int v, input int budget, input bit poke,
                          output int lat, output int eocs, output int res, output int samp,
                          output bit glitch, output bit busy_end);
      int c0, tn, dprev;
      bit seen, prev_s, poked, s, rc, e;
      lat = -1; eocs = 0; res = -1; samp = 0; glitch = 0; seen = 0; prev_s = 0; poked = 0;
      tn = 0;
      if (sel) vin12 = v; else vin10 = v;
      dprev = sel ? int'(dout12) : int'(dout10);
      c0 = cyc;
      if (sel) start12 = 1'b1; else start10 = 1'b1;
      @(negedge clk);
      for (int i = 0; i < budget; i++) begin
         start10 = 1'b0;
         start12 = 1'b0;
         s  = sel ? samp12 : samp10;
         rc = sel ? regclk12 : regclk10;
         e  = sel ? eoc12 : eoc10;
         if (s && !prev_s && vin_seq.size() > 0) begin
            if (sel) vin12 = vin_seq.pop_front(); else vin10 = vin_seq.pop_front();
         end
         prev_s = s;
         if (s && !seen) samp++;
         if (rc && !seen && tn < 16) begin
            trace[tn] = sel ? int'(d12) : int'(d10);
            tn++;
         end
         if (poke && rc && !poked) begin
            if (sel) start12 = 1'b1; else start10 = 1'b1;
            poked = 1'b1;
         end
         if (e) begin
            eocs++;
            if (!seen) begin
               lat  = cyc - c0;
               res  = sel ? int'(dout12) : int'(dout10);
               seen = 1'b1;
            end
         end else if (!seen && (sel ? int'(dout12) : int'(dout10)) != dprev) begin
            glitch = 1'b1;
         end
         @(negedge clk);
      end
      busy_end = sel ? busy12 : busy10;
   endtask

   initial begin
      int lat, eocs, res, samp, kc, n, c0, v, b, sum;
      bit gl, bend;
      int et[8];
      rst_n = 1'b0; start10 = 1'b0; start12 = 1'b0; cont10 = 1'b0; cont12 = 1'b0;
      force_en = 1'b0; force_val = 1'b0; vin10 = 0; vin12 = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_outs10", {d10, dout10, samp10, regclk10, busy10, eoc10}, 0);
      check_eq("rst_outs12", {d12, dout12, samp12, regclk12, busy12, eoc12}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single conversion with full D trajectory
      v = 'h2A5;
      do_conv(0, v, L10 + 10, 0, lat, eocs, res, samp, gl, bend);
      for (int i = 0; i < N10; i++) begin
         b = N10 - 1 - i;
         check_eq($sformatf("trace%0d", i), trace[i], ((v >> b) | 1) << b);
      end
      check_eq("single_lat", lat, L10);
      check_eq("single_eocs", eocs, 1);
      check_eq("single_dout", res, v);
      check_eq("single_samp", samp, S10 << A);
      check_eq("single_hold", gl, 0);
      check_eq("single_idle", bend, 0);

      // Comparator tied low, then high
      force_en = 1'b1;
      force_val = 1'b0;
      do_conv(0, 0, L10 + 6, 0, lat, eocs, res, samp, gl, bend);
      check_eq("tied0_dout", res, 0);
      check_eq("tied0_samp", samp, S10 << A);
      force_val = 1'b1;
      do_conv(0, 0, L10 + 6, 0, lat, eocs, res, samp, gl, bend);
      check_eq("tied1_dout", res, 'h3FF);
      check_eq("tied1_samp", samp, S10 << A);
      check_eq("tied1_lat", lat, L10);
      force_en = 1'b0;

      // Reset in the k=5 CONVERT cycle
      vin10 = 'h2A5;
      start10 = 1'b1;
      @(negedge clk);
      start10 = 1'b0;
      kc = 0;
      for (int i = 0; i < 40 && kc < 5; i++) begin
         if (regclk10) kc++;
         if (kc < 5) @(negedge clk);
      end
      check_eq("rst_reach_k5", kc, 5);
      check_eq("rst_k5_D", d10, ((v >> 5) | 1) << 5);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_conv_outs", {d10, dout10, samp10, regclk10, busy10, eoc10}, 0);
      rst_n = 1'b1;
      n = 0;
      kc = 0;
      for (int i = 0; i < 2 * L10; i++) begin
         @(negedge clk);
         if (eoc10) n++;
         if (busy10) kc++;
      end
      check_eq("rst_no_eoc", n, 0);
      check_eq("rst_no_busy", kc, 0);

      // Continuous mode, drop cont_mode in the 4th conversion
      vin10 = 'h155;
      c0 = cyc;
      cont10 = 1'b1;
      n = 0;
      for (int i = 0; i < 4 * L10 + 20; i++) begin
         @(negedge clk);
         if (eoc10) begin
            if (n < 8) et[n] = cyc;
            n++;
            check_eq($sformatf("cont_dout%0d", n), dout10, 'h155);
         end
         if (n == 3 && regclk10 && cont10) cont10 = 1'b0;
      end
      cont10 = 1'b0;
      check_eq("cont_eocs", n, 4);
      check_eq("cont_first", et[0] - c0, L10);
      for (int i = 1; i < 4; i++) check_eq($sformatf("cont_period%0d", i), et[i] - et[i-1], L10);
      check_eq("cont_idle", busy10, 0);

      // start pulse while busy is ignored
      do_conv(0, 'h3C3, 2 * L10 + 10, 1, lat, eocs, res, samp, gl, bend);
      check_eq("busy_eocs", eocs, 1);
      check_eq("busy_dout", res, 'h3C3);
      check_eq("busy_lat", lat, L10);
      check_eq("busy_idle", bend, 0);

      // 12-bit instance, random inputs
      for (int t = 0; t < 20; t++) begin
         v = int'($urandom_range(0, 4095));
         do_conv(1, v, L12 + 6, 0, lat, eocs, res, samp, gl, bend);
         check_eq($sformatf("w12_dout%0d", t), res, v);
         check_eq($sformatf("w12_lat%0d", t), lat, L12);
         check_eq($sformatf("w12_eocs%0d", t), eocs, 1);
      end

`ifdef SAR_AVG_EN
      // Per-conversion Vin changes; result is the truncated mean
      vin_seq = '{'h100, 'h101, 'h102, 'h103};
      sum = 0;
      foreach (vin_seq[i]) sum += vin_seq[i];
      do_conv(0, 'h100, L10 + 10, 0, lat, eocs, res, samp, gl, bend);
      check_eq("avg_lat", lat, 52);
      check_eq("avg_eocs", eocs, 1);
      check_eq("avg_dout", res, sum >> A);
      check_eq("avg_hold", gl, 0);
      check_eq("avg_idle", bend, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
